// File: rtl/icb_arb_pkg.sv
// Shared definitions for the 2:1 ICB arbiter.
// - arb_state_e : arbiter FSM state encoding
// - IcbAw/IcbDw : default ICB address/data widths
package icb_arb_pkg;

  localparam int unsigned IcbAw = 32;
  localparam int unsigned IcbDw = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLock    = 2'd1,
    StWaitRsp = 2'd2,
    StDrain   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/icb_2to1_arb_if.sv
// One ICB port (command + response channels).
// Ports: none; signals cmd_valid/ready/addr/read/wdata/wmask, rsp_valid/ready/rdata/err.
// Modports: master (issues commands), slave (accepts commands).
interface icb_2to1_arb_if
  import icb_arb_pkg::*;
#(
  parameter int unsigned AW = IcbAw,
  parameter int unsigned DW = IcbDw
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/icb_rr_sel2.sv
// Combinational 2-input round-robin selector.
// Ports: valid_i[1:0] requests, rr_last_i last served index, sel_o chosen index.
module icb_rr_sel2 (
  input  logic [1:0] valid_i,
  input  logic       rr_last_i,
  output logic       sel_o
);
  always_comb begin
    sel_o = ~rr_last_i;
    unique case (valid_i)
      2'b01:   sel_o = 1'b0;
      2'b10:   sel_o = 1'b1;
      default: sel_o = ~rr_last_i;
    endcase
  end
endmodule

// File: rtl/icb_2to1_arb.sv
// Two-master to one-slave ICB arbiter, round-robin, one outstanding transaction.
// Ports: clk, rst_n (async active-low), m0/m1 master-side ICB ports (slave modport),
//        s slave-side ICB port (master modport), arb_timeout one-cycle timeout pulse.
// Optional: define ICB_2TO1_ARB_RSP_TIMEOUT_EN to bound the response wait to
//           TIMEOUT_CYC cycles, returning an error response and draining the late one.
module icb_2to1_arb
  import icb_arb_pkg::*;
#(
  parameter int unsigned AW          = IcbAw,
  parameter int unsigned DW          = IcbDw,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  icb_2to1_arb_if.slave   m0,
  icb_2to1_arb_if.slave   m1,
  icb_2to1_arb_if.master  s,
  output logic            arb_timeout
);

  if (TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("TIMEOUT_CYC must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic rr_last_q, rr_last_d;

  logic [1:0]      req;
  logic            sel, grant;
  logic            g_valid, g_read;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic [DW/8-1:0] g_wmask;
  logic            own_rsp_ready;

  logic            cmd_vld, cmd_rdy, s_rsp_rdy, rsp_vld, rsp_err, to_pulse;
  logic [DW-1:0]   rsp_rdata;

  assign req = {m1.cmd_valid, m0.cmd_valid};

  icb_rr_sel2 u_rr_sel (
    .valid_i   (req),
    .rr_last_i (rr_last_q),
    .sel_o     (sel)
  );

  // Grant follows the selector only in idle; otherwise it is frozen to the owner.
  assign grant         = (state_q == StIdle) ? sel : owner_q;
  assign g_valid       = grant ? m1.cmd_valid : m0.cmd_valid;
  assign g_read        = grant ? m1.cmd_read  : m0.cmd_read;
  assign g_addr        = grant ? m1.cmd_addr  : m0.cmd_addr;
  assign g_wdata       = grant ? m1.cmd_wdata : m0.cmd_wdata;
  assign g_wmask       = grant ? m1.cmd_wmask : m0.cmd_wmask;
  assign own_rsp_ready = owner_q ? m1.rsp_ready : m0.rsp_ready;

`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;  // error response is being held for the owner
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cmd_vld   = 1'b0;
    cmd_rdy   = 1'b0;
    s_rsp_rdy = 1'b0;
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    to_pulse  = 1'b0;
`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
    to_d      = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          cmd_vld = 1'b1;
          cmd_rdy = s.cmd_ready;
          owner_d = sel;
          state_d = s.cmd_ready ? StWaitRsp : StLock;
        end
      end
      StLock: begin
        if (!g_valid) begin
          state_d = StIdle;
        end else begin
          cmd_vld = 1'b1;
          cmd_rdy = s.cmd_ready;
          if (s.cmd_ready) state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
        // A real slave response beats a timeout landing in the same cycle.
        if (!to_q && s.rsp_valid) begin
          s_rsp_rdy = own_rsp_ready;
          rsp_vld   = 1'b1;
          rsp_rdata = s.rsp_rdata;
          rsp_err   = s.rsp_err;
          if (own_rsp_ready) begin
            rr_last_d = owner_q;
            state_d   = StIdle;
          end
        end else if (to_q || (cnt_q == CntW'(TIMEOUT_CYC - 1))) begin
          rsp_vld  = 1'b1;
          rsp_err  = 1'b1;
          to_pulse = ~to_q;
          if (own_rsp_ready) begin
            rr_last_d = owner_q;
            to_d      = 1'b0;
            state_d   = StDrain;
          end else begin
            to_d = 1'b1;
          end
        end
`else
        s_rsp_rdy = own_rsp_ready;
        rsp_vld   = s.rsp_valid;
        if (s.rsp_valid) begin
          rsp_rdata = s.rsp_rdata;
          rsp_err   = s.rsp_err;
          if (own_rsp_ready) begin
            rr_last_d = owner_q;
            state_d   = StIdle;
          end
        end
`endif
      end
`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
      StDrain: begin
        // Swallow the late response of the timed-out transaction.
        s_rsp_rdy = 1'b1;
        if (s.rsp_valid) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
  always_comb begin
    cnt_d = '0;
    if (state_q == StWaitRsp) begin
      cnt_d = cnt_q;
      if (!(s.rsp_valid && s_rsp_rdy) && (cnt_q != CntW'(TIMEOUT_CYC - 1))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Outputs are forced low while reset is asserted, independent of master inputs.
  logic cmd_out, rdy_out, rsp0_out, rsp1_out;
  assign cmd_out  = rst_n & cmd_vld;
  assign rdy_out  = rst_n & cmd_rdy;
  assign rsp0_out = rst_n & rsp_vld & ~owner_q;
  assign rsp1_out = rst_n & rsp_vld & owner_q;

  assign s.cmd_valid = cmd_out;
  assign s.cmd_addr  = cmd_out ? g_addr  : '0;
  assign s.cmd_read  = cmd_out & g_read;
  assign s.cmd_wdata = cmd_out ? g_wdata : '0;
  assign s.cmd_wmask = cmd_out ? g_wmask : '0;
  assign s.rsp_ready = rst_n & s_rsp_rdy;

  assign m0.cmd_ready = rdy_out & ~grant;
  assign m1.cmd_ready = rdy_out & grant;
  assign m0.rsp_valid = rsp0_out;
  assign m1.rsp_valid = rsp1_out;
  assign m0.rsp_rdata = rsp0_out ? rsp_rdata : '0;
  assign m1.rsp_rdata = rsp1_out ? rsp_rdata : '0;
  assign m0.rsp_err   = rsp0_out & rsp_err;
  assign m1.rsp_err   = rsp1_out & rsp_err;

  assign arb_timeout = rst_n & to_pulse;

endmodule

// File: tb/tb_icb_2to1_arb.sv
// Directed self-checking bench for icb_2to1_arb (TIMEOUT_CYC=16).
module tb_icb_2to1_arb;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_timeout;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  icb_2to1_arb_if #(.AW(32), .DW(32)) m0_if ();
  icb_2to1_arb_if #(.AW(32), .DW(32)) m1_if ();
  icb_2to1_arb_if #(.AW(32), .DW(32)) s_if ();

  icb_2to1_arb #(.AW(32), .DW(32), .TIMEOUT_CYC(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .arb_timeout (arb_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " s.cmd_valid"}, 64'(s_if.cmd_valid), 64'd0);
    chk({tag, " s.rsp_ready"}, 64'(s_if.rsp_ready), 64'd0);
    chk({tag, " m0.cmd_ready"}, 64'(m0_if.cmd_ready), 64'd0);
    chk({tag, " m1.cmd_ready"}, 64'(m1_if.cmd_ready), 64'd0);
    chk({tag, " m0.rsp_valid"}, 64'(m0_if.rsp_valid), 64'd0);
    chk({tag, " m1.rsp_valid"}, 64'(m1_if.rsp_valid), 64'd0);
    chk({tag, " m1.rsp_rdata"}, 64'(m1_if.rsp_rdata), 64'd0);
    chk({tag, " arb_timeout"}, 64'(arb_timeout), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_if.cmd_valid = 1'b1; m0_if.cmd_addr = 32'h0; m0_if.cmd_read = 1'b0;
    m0_if.cmd_wdata = 32'h0; m0_if.cmd_wmask = 4'h0; m0_if.rsp_ready = 1'b0;
    m1_if.cmd_valid = 1'b1; m1_if.cmd_addr = 32'h0; m1_if.cmd_read = 1'b0;
    m1_if.cmd_wdata = 32'h0; m1_if.cmd_wmask = 4'h0; m1_if.rsp_ready = 1'b0;
    s_if.cmd_ready = 1'b1; s_if.rsp_valid = 1'b0; s_if.rsp_rdata = 32'h0; s_if.rsp_err = 1'b0;
    #2;
    chk_all_zero("reset");
    m0_if.cmd_valid = 1'b0;
    m1_if.cmd_valid = 1'b0;
    #10 rst_n = 1'b1;

    // Single m0 read, slave answers the cycle after accept.
    cyc();
    m0_if.cmd_valid = 1'b1; m0_if.cmd_read = 1'b1; m0_if.cmd_addr = 32'h1001_3000;
    m0_if.cmd_wmask = 4'hF;
    #1;
    chk("t1 s.cmd_valid", 64'(s_if.cmd_valid), 64'd1);
    chk("t1 s.cmd_addr", 64'(s_if.cmd_addr), 64'h1001_3000);
    chk("t1 s.cmd_read", 64'(s_if.cmd_read), 64'd1);
    chk("t1 s.cmd_wmask", 64'(s_if.cmd_wmask), 64'hF);
    chk("t1 m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd1);
    chk("t1 m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd0);
    cyc();
    m0_if.cmd_valid = 1'b0;
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'hA5; s_if.rsp_err = 1'b0;
    m0_if.rsp_ready = 1'b1;
    #1;
    chk("t1 m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
    chk("t1 m0.rsp_rdata", 64'(m0_if.rsp_rdata), 64'hA5);
    chk("t1 m0.rsp_err", 64'(m0_if.rsp_err), 64'd0);
    chk("t1 m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd0);
    chk("t1 s.rsp_ready", 64'(s_if.rsp_ready), 64'd1);
    chk("t1 wait s.cmd_valid", 64'(s_if.cmd_valid), 64'd0);
    cyc();
    s_if.rsp_valid = 1'b0;
    #1;
    chk("t1 after m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
    chk("t1 after s.cmd_valid", 64'(s_if.cmd_valid), 64'd0);

    // Fresh reset, then both masters continuously valid: m0,m1,m0,m1,m0,m1.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_if.cmd_valid = 1'b1; m0_if.cmd_read = 1'b0; m0_if.cmd_addr = 32'hA000_0000;
    m0_if.cmd_wdata = 32'hA0;
    m1_if.cmd_valid = 1'b1; m1_if.cmd_read = 1'b0; m1_if.cmd_addr = 32'hB000_0000;
    m1_if.cmd_wdata = 32'hB1;
    m0_if.rsp_ready = 1'b1; m1_if.rsp_ready = 1'b1;
    s_if.cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("t2 addr m0", 64'(s_if.cmd_addr), 64'hA000_0000);
        chk("t2 wdata m0", 64'(s_if.cmd_wdata), 64'hA0);
        chk("t2 m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd1);
        chk("t2 m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd0);
      end else begin
        chk("t2 addr m1", 64'(s_if.cmd_addr), 64'hB000_0000);
        chk("t2 wdata m1", 64'(s_if.cmd_wdata), 64'hB1);
        chk("t2 m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd1);
        chk("t2 m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd0);
      end
      cyc();
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h1000 + 32'(i);
      #1;
      chk("t2 wait s.cmd_valid", 64'(s_if.cmd_valid), 64'd0);
      if (i % 2 == 0) begin
        chk("t2 m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
        chk("t2 m0.rsp_rdata", 64'(m0_if.rsp_rdata), 64'h1000 + 64'(i));
        chk("t2 m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd0);
      end else begin
        chk("t2 m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd1);
        chk("t2 m1.rsp_rdata", 64'(m1_if.rsp_rdata), 64'h1000 + 64'(i));
        chk("t2 m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
      end
      cyc();
      s_if.rsp_valid = 1'b0;
    end
    m0_if.cmd_valid = 1'b0;
    m1_if.cmd_valid = 1'b0;

    // m1 locked while slave stalls; m0 joins on cycle 2 and must wait.
    cyc();
    m1_if.cmd_valid = 1'b1; m1_if.cmd_read = 1'b1; m1_if.cmd_addr = 32'hC000_0004;
    m0_if.cmd_addr = 32'hD000_0008; m0_if.cmd_read = 1'b1;
    s_if.cmd_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2) m0_if.cmd_valid = 1'b1;
      #1;
      chk("t3 lock addr", 64'(s_if.cmd_addr), 64'hC000_0004);
      chk("t3 lock m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd0);
      cyc();
    end
    s_if.cmd_ready = 1'b1;
    #1;
    chk("t3 accept m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd1);
    chk("t3 accept m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd0);
    cyc();
    m1_if.cmd_valid = 1'b0;
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h33;
    #1;
    chk("t3 m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd1);
    chk("t3 wait m0.cmd_ready", 64'(m0_if.cmd_ready), 64'd0);
    cyc();
    s_if.rsp_valid = 1'b0;
    #1;
    chk("t3 m0 granted addr", 64'(s_if.cmd_addr), 64'hD000_0008);
    chk("t3 m0 granted ready", 64'(m0_if.cmd_ready), 64'd1);
    cyc();

    // Owner m0 back-pressures the response for 3 cycles.
    m0_if.cmd_valid = 1'b0; m0_if.rsp_ready = 1'b0;
    m1_if.cmd_valid = 1'b1; m1_if.cmd_addr = 32'hE000_0000;
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h77; s_if.rsp_err = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4 s.rsp_ready", 64'(s_if.rsp_ready), 64'd0);
      chk("t4 m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
      chk("t4 m0.rsp_rdata", 64'(m0_if.rsp_rdata), 64'h77);
      chk("t4 m0.rsp_err", 64'(m0_if.rsp_err), 64'd1);
      chk("t4 m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd0);
      chk("t4 s.cmd_valid", 64'(s_if.cmd_valid), 64'd0);
      cyc();
    end
    m0_if.rsp_ready = 1'b1;
    #1;
    chk("t4 release s.rsp_ready", 64'(s_if.rsp_ready), 64'd1);
    cyc();
    s_if.rsp_valid = 1'b0; s_if.rsp_err = 1'b0;
    #1;
    chk("t4 m1 granted addr", 64'(s_if.cmd_addr), 64'hE000_0000);
    chk("t4 m1 granted ready", 64'(m1_if.cmd_ready), 64'd1);
    cyc();

    // Reset while m1's response is in flight.
    m0_if.cmd_valid = 1'b1;
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h55;
    #1;
    chk("t5 pre m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5 reset");
    s_if.rsp_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("t5 m0 wins addr", 64'(s_if.cmd_addr), 64'hD000_0008);
    chk("t5 m0 wins ready", 64'(m0_if.cmd_ready), 64'd1);
    chk("t5 m1 loses ready", 64'(m1_if.cmd_ready), 64'd0);
    cyc();

    // Slave never answers m0's command.
    m0_if.cmd_valid = 1'b0; m1_if.cmd_valid = 1'b0; m0_if.rsp_ready = 1'b0;
`ifdef ICB_2TO1_ARB_RSP_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("t6 pre m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
      chk("t6 pre arb_timeout", 64'(arb_timeout), 64'd0);
      cyc();
    end
    #1;
    chk("t6 to m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
    chk("t6 to m0.rsp_err", 64'(m0_if.rsp_err), 64'd1);
    chk("t6 to m0.rsp_rdata", 64'(m0_if.rsp_rdata), 64'd0);
    chk("t6 to arb_timeout", 64'(arb_timeout), 64'd1);
    cyc();
    #1;
    chk("t6 hold m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
    chk("t6 hold arb_timeout", 64'(arb_timeout), 64'd0);
    m0_if.rsp_ready = 1'b1;
    cyc();
    m1_if.cmd_valid = 1'b1;
    for (int k = 17; k < 25; k++) begin
      #1;
      chk("t6 drain s.rsp_ready", 64'(s_if.rsp_ready), 64'd1);
      chk("t6 drain m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd0);
      chk("t6 drain m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
      chk("t6 drain arb_timeout", 64'(arb_timeout), 64'd0);
      cyc();
    end
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h99;
    #1;
    chk("t6 late m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
    chk("t6 late m1.rsp_valid", 64'(m1_if.rsp_valid), 64'd0);
    cyc();
    s_if.rsp_valid = 1'b0;
    #1;
    chk("t6 idle m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd1);
`else
    for (int k = 0; k < 25; k++) begin
      #1;
      chk("t6 wait m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd0);
      chk("t6 wait arb_timeout", 64'(arb_timeout), 64'd0);
      cyc();
    end
    s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h99; m0_if.rsp_ready = 1'b1;
    #1;
    chk("t6 late m0.rsp_valid", 64'(m0_if.rsp_valid), 64'd1);
    chk("t6 late m0.rsp_rdata", 64'(m0_if.rsp_rdata), 64'h99);
    cyc();
    s_if.rsp_valid = 1'b0;
    m1_if.cmd_valid = 1'b1;
    #1;
    chk("t6 idle m1.cmd_ready", 64'(m1_if.cmd_ready), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
